tdc_fifo_writer: RTL and testbench

- Downstream neighbour of the TDC request generator. Consumes its level-held write request (wr_en) and serialises one 16-bit TDC sample into a byte-wide FIFO, high byte first.
- Returns a one-cycle f_FIFO_writing_done pulse, which clears the upstream request.
- Handles FIFO back-pressure with a bounded stall. On timeout it drops the sample and counts the drop.

---
 rtl/tdc_pkg.sv | 25 ++
 rtl/sat_counter.sv | 28 ++
 rtl/tdc_fifo_writer.sv | 134 +++++++++++++
 tb/tb_tdc_fifo_writer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC FIFO writer: state encodings, widths, helpers.
package tdc_pkg;

    localparam int TDC_DATA_W  = 16;
    localparam int FIFO_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_HI = 3'd1,
        WR_LO = 3'd2,
        ABORT = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Number of bits needed to count 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment on request unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/tdc_fifo_writer.sv
// Serialises one TDC sample per upstream request into a byte-wide FIFO,
// high byte first, with a bounded per-byte stall on fifo_full.
module tdc_fifo_writer
    import tdc_pkg::*;
#(
    parameter int DATA_W    = TDC_DATA_W,
    parameter int BYTE_W    = FIFO_BYTE_W,
    parameter int STALL_MAX = 1024,
    parameter int DROP_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] tdc_data,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [BYTE_W-1:0] fifo_din,
    output logic              f_FIFO_writing_done,
    output logic [15:0]       sample_cnt,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    localparam int                 STALL_W    = clog2(STALL_MAX);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

    state_e             state_q, state_d;
    logic               armed_q, armed_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [15:0]        sample_cnt_q, sample_cnt_d;
    logic               drop_inc;

    // Next-state logic: accept, byte writes with stall timeout, abort, done.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        shreg_d      = shreg_q;
        stall_cnt_d  = stall_cnt_q;
        sample_cnt_d = sample_cnt_q;
        drop_inc     = 1'b0;

        // A low request re-arms; this keeps a still-held request from being
        // taken twice while upstream is reacting to the done pulse.
        if (!wr_req) armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (wr_req && armed_q) begin
                    shreg_d     = tdc_data;
                    armed_d     = 1'b0;
                    stall_cnt_d = '0;
                    state_d     = WR_HI;
                end
            end
            WR_HI, WR_LO: begin
                if (!fifo_full) begin
                    stall_cnt_d = '0;
                    if (state_q == WR_HI) begin
                        state_d = WR_LO;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 16'd1;
                        state_d      = DONE;
                    end
                end else if (stall_cnt_q == STALL_LAST) begin
                    state_d = ABORT;
                end else begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end
            end
            ABORT: begin
                drop_inc = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            armed_q      <= 1'b1;
            shreg_q      <= '0;
            stall_cnt_q  <= '0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            shreg_q      <= shreg_d;
            stall_cnt_q  <= stall_cnt_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // FIFO strobe and byte mux decoded from the registered state.
    always_comb begin
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        case (state_q)
            WR_HI: begin
                fifo_wr_en = !fifo_full;
                fifo_din   = shreg_q[DATA_W-1 -: BYTE_W];
            end
            WR_LO: begin
                fifo_wr_en = !fifo_full;
                fifo_din   = shreg_q[BYTE_W-1:0];
            end
            default: begin
                fifo_wr_en = 1'b0;
                fifo_din   = '0;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (DROP_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

    assign f_FIFO_writing_done = (state_q == DONE);
    assign busy                = (state_q != IDLE);
    assign sample_cnt          = sample_cnt_q;

endmodule

// File: tb/tb_tdc_fifo_writer.sv
// Randomised bench for tdc_fifo_writer with a transaction-level reference model.
module tb_tdc_fifo_writer;

    localparam int STALL_MAX = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req = 1'b0;
    logic [15:0] tdc_data = 16'h0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        f_FIFO_writing_done;
    logic [15:0] sample_cnt;
    logic [7:0]  drop_cnt;
    logic        busy;

    always #5 clk = ~clk;

    tdc_fifo_writer #(
        .DATA_W    (16),
        .BYTE_W    (8),
        .STALL_MAX (STALL_MAX),
        .DROP_W    (8)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_req              (wr_req),
        .tdc_data            (tdc_data),
        .fifo_full           (fifo_full),
        .fifo_wr_en          (fifo_wr_en),
        .fifo_din            (fifo_din),
        .f_FIFO_writing_done (f_FIFO_writing_done),
        .sample_cnt          (sample_cnt),
        .drop_cnt            (drop_cnt),
        .busy                (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes still owed to the FIFO, stall run length,
    // pending abort/done pulses, re-arm flag and the two counters.
    logic [7:0]  mq[$];
    int          m_stall;
    bit          m_abort, m_done, m_armed;
    logic [15:0] m_samples;
    logic [7:0]  m_drops;
    logic [7:0]  wr_log[$];
    logic        e_busy, e_wr;
    logic [7:0]  e_din;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_stall   = 0;
            m_abort   = 1'b0;
            m_done    = 1'b0;
            m_armed   = 1'b1;
            m_samples = 16'h0;
            m_drops   = 8'h0;
        end
        e_busy = (mq.size() != 0) || m_abort || m_done;
        e_wr   = (mq.size() != 0) && !fifo_full;
        e_din  = (mq.size() != 0) ? mq[0] : 8'h00;
        chk("busy", busy, e_busy);
        chk("fifo_wr_en", fifo_wr_en, e_wr);
        chk("fifo_din", fifo_din, e_din);
        chk("done", f_FIFO_writing_done, m_done);
        chk("sample_cnt", sample_cnt, m_samples);
        chk("drop_cnt", drop_cnt, m_drops);
        if (fifo_wr_en) wr_log.push_back(fifo_din);
        if (rst_n) begin
            if (!wr_req) m_armed = 1'b1;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_abort) begin
                m_abort = 1'b0;
                if (m_drops != 8'hFF) m_drops++;
                m_done = 1'b1;
            end else if (mq.size() != 0) begin
                if (!fifo_full) begin
                    void'(mq.pop_front());
                    m_stall = 0;
                    if (mq.size() == 0) begin
                        m_samples++;
                        m_done = 1'b1;
                    end
                end else if (m_stall == STALL_MAX - 1) begin
                    mq.delete();
                    m_abort = 1'b1;
                end else begin
                    m_stall++;
                end
            end else if (wr_req && m_armed) begin
                mq.push_back(tdc_data[15:8]);
                mq.push_back(tdc_data[7:0]);
                m_armed = 1'b0;
                m_stall = 0;
            end
        end
    end

    // Upstream: raise request, wait for done (k counts cycles from the
    // accept cycle = 1), drop the request in the following cycle.
    task automatic send(input logic [15:0] d, input int maxc, output int done_at);
        @(posedge clk);
        #1;
        wr_req   = 1'b1;
        tdc_data = d;
        done_at  = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (f_FIFO_writing_done) begin
                done_at = k;
                break;
            end
        end
        chk("send_done_seen", (done_at > 0), 1);
        @(posedge clk);
        #1;
        wr_req   = 1'b0;
        tdc_data = 16'($urandom);
    endtask

    logic [7:0] exp_bytes[$];
    int         d;
    int         ndone;
    int         nbad;
    bit         stop_full;
    logic [15:0] dat;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_done", f_FIFO_writing_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_samples", sample_cnt, 0);
        chk("rst_drops", drop_cnt, 0);
        rst_n = 1'b1;

        // Basic write
        wr_log.delete();
        send(16'hA55A, 50, d);
        chk("basic_done_lat", d, 4);
        chk("basic_nbytes", wr_log.size(), 2);
        chk("basic_b0", (wr_log.size() > 0) ? wr_log[0] : 32'hDEAD, 8'hA5);
        chk("basic_b1", (wr_log.size() > 1) ? wr_log[1] : 32'hDEAD, 8'h5A);
        chk("basic_samples", sample_cnt, 1);

        // Back-pressure: full for 10 cycles starting at the low-byte cycle
        wr_log.delete();
        fork
            send(16'h1234, 100, d);
            begin
                repeat (3) @(posedge clk);
                #1 fifo_full = 1'b1;
                repeat (10) @(posedge clk);
                #1 fifo_full = 1'b0;
            end
        join
        chk("bp_done_lat", d, 14);
        chk("bp_nbytes", wr_log.size(), 2);
        chk("bp_b0", (wr_log.size() > 0) ? wr_log[0] : 32'hDEAD, 8'h12);
        chk("bp_b1", (wr_log.size() > 1) ? wr_log[1] : 32'hDEAD, 8'h34);
        chk("bp_drops", drop_cnt, 0);
        chk("bp_samples", sample_cnt, 2);

        // Timeout: full held throughout
        wr_log.delete();
        fifo_full = 1'b1;
        send(16'hBEEF, 200, d);
        fifo_full = 1'b0;
        chk("to_done_lat", d, STALL_MAX + 3);
        chk("to_nbytes", wr_log.size(), 0);
        chk("to_drops", drop_cnt, 1);
        chk("to_samples", sample_cnt, 2);

        // Held request: one sample only until the request drops
        wr_log.delete();
        ndone = 0;
        @(posedge clk);
        #1;
        wr_req   = 1'b1;
        tdc_data = 16'hC3D2;
        repeat (20) begin
            @(negedge clk);
            if (f_FIFO_writing_done) ndone++;
        end
        chk("held_nbytes", wr_log.size(), 2);
        chk("held_ndone", ndone, 1);
        @(posedge clk);
        #1 wr_req = 1'b0;
        send(16'h7E81, 50, d);
        chk("held_rearm_lat", d, 4);
        chk("held_b2", (wr_log.size() > 2) ? wr_log[2] : 32'hDEAD, 8'h7E);
        chk("held_samples", sample_cnt, 4);

        // Periodic randomised traffic with random back-pressure
        wr_log.delete();
        exp_bytes.delete();
        stop_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    dat = 16'($urandom);
                    exp_bytes.push_back(dat[15:8]);
                    exp_bytes.push_back(dat[7:0]);
                    send(dat, 400, d);
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                end
                stop_full = 1'b1;
            end
            begin
                while (!stop_full) begin
                    @(posedge clk);
                    #1 fifo_full = ($urandom_range(0, 3) == 0);
                end
                fifo_full = 1'b0;
            end
        join
        chk("per_nbytes", wr_log.size(), 600);
        nbad = 0;
        for (int i = 0; i < 600; i++) begin
            if (i >= wr_log.size() || wr_log[i] !== exp_bytes[i]) nbad++;
        end
        chk("per_stream_mismatches", nbad, 0);
        chk("per_samples", sample_cnt, 16'd304);

        // Sample counter wrap
        @(posedge clk);
        #1;
        force dut.sample_cnt_q = 16'hFFFE;
        m_samples = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.sample_cnt_q;
        chk("wrap_preload", sample_cnt, 16'hFFFE);
        send(16'h0102, 50, d);
        send(16'h0304, 50, d);
        chk("wrap_zero", sample_cnt, 16'h0000);
        send(16'h0506, 50, d);
        chk("wrap_one", sample_cnt, 16'h0001);

        // Reset during the low-byte cycle
        @(posedge clk);
        #1;
        wr_req   = 1'b1;
        tdc_data = 16'h5AA5;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", fifo_wr_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", f_FIFO_writing_done, 0);
        chk("midrst_samples", sample_cnt, 0);
        chk("midrst_drops", drop_cnt, 0);
        wr_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(16'h0F0F, 50, d);
        chk("postrst_lat", d, 4);
        chk("postrst_samples", sample_cnt, 1);

        // Drop counter saturation
        fifo_full = 1'b1;
        for (int i = 0; i < 260; i++) begin
            send(16'($urandom), 200, d);
            if (i == 254) chk("sat_reach", drop_cnt, 8'hFF);
        end
        fifo_full = 1'b0;
        chk("sat_hold", drop_cnt, 8'hFF);
        chk("sat_samples", sample_cnt, 1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
